// File: rtl/m0_pkg.sv
// m0 shared definitions: deframer FSM encoding,
// serial frame levels and default word width.
package m0_pkg;

  localparam int DFLT_DATA_W = 16;

  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

endpackage

// File: rtl/m0_serial_deframer_if.sv
// Parallel word output bundle of the deframer:
// word plus parity sideband on a valid/ready handshake.
interface m0_serial_deframer_if
  import m0_pkg::*;
#(
  parameter int DATA_W = DFLT_DATA_W
);

  logic [DATA_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;
  logic              parity_err;

  modport master (
    output word_out,
    output word_valid,
    output parity_err,
    input  word_ready
  );

  modport slave (
    input  word_out,
    input  word_valid,
    input  parity_err,
    output word_ready
  );

endinterface

// File: rtl/m0_out_hold.sv
// Single-entry holding register for assembled words,
// with sticky overrun when a word arrives while full.
module m0_out_hold #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              pin,
  m0_serial_deframer_if.master out,
  output logic              overrun
);

  logic room;

  // Free slot, or the current word leaves on this same edge.
  assign room = !out.word_valid || out.word_ready;

  // Load, drop-with-overrun, or retire the held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out.word_out   <= '0;
      out.word_valid <= 1'b0;
      out.parity_err <= 1'b0;
      overrun        <= 1'b0;
    end else if (load && room) begin
      out.word_out   <= din;
      out.parity_err <= pin;
      out.word_valid <= 1'b1;
    end else if (load) begin
      overrun <= 1'b1;
    end else if (out.word_valid && out.word_ready) begin
      out.word_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/m0_serial_deframer.sv
// Serial deframer: start, LSB-first data, optional
// even parity, stop; delivers words via a holding register.
module m0_serial_deframer
  import m0_pkg::*;
#(
  parameter int DATA_W    = DFLT_DATA_W,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic en,
  m0_serial_deframer_if.master out,
  output logic frame_err,
  output logic overrun,
  output logic busy
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [DATA_W-1:0] acc, acc_n;
  logic              par, par_n;
  logic              ferr_n;
  logic              load;

  // Frame state, bit counter, accumulator, error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      par       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      acc       <= acc_n;
      par       <= par_n;
      frame_err <= ferr_n;
    end
  end

  // Next-state logic; everything holds on en=0 edges.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc_n   = acc;
    par_n   = par;
    ferr_n  = 1'b0;
    load    = 1'b0;
    if (en) begin
      unique case (state)
        IDLE: begin
          if (bit_in == START_LVL) begin
            state_n = DATA;
            cnt_n   = '0;
            par_n   = 1'b0;
          end
        end
        DATA: begin
          acc_n = {bit_in, acc[DATA_W-1:1]};
          cnt_n = cnt + CW'(1);
          if (cnt == LAST) begin
            state_n = PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_n   = (^acc) ^ bit_in;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (bit_in == STOP_LVL) begin
            load = 1'b1;
          end else begin
            ferr_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  m0_out_hold #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .din     (acc),
    .pin     (par),
    .out     (out),
    .overrun (overrun)
  );

endmodule

// File: doc/m0_serial_deframer.md
Name: m0_serial_deframer

Overview:
- Downstream consumer of the per-pin 16-bit shift-register delay line.
- Takes the delayed single-bit stream (one bit per enabled clk) and locates frames of the form: start bit, DATA_W data bits LSB-first, optional even-parity bit, stop bit.
- Assembles each frame into a parallel word and presents it on a valid/ready output with parity, framing and overrun status.
- Sits between the shift_reg output pin and the M0 word-level logic.

Parameters:
- DATA_W, 16: data bits per frame; legal range 2..16.
- PARITY_EN, 1: 1 = parity bit present and checked; 0 = frame goes directly from data to stop.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- bit_in  in  1  serial stream from the shift_reg out.
- en  in  1  bit strobe; bit_in is sampled only on a clk edge with en=1.
- word_out  out  DATA_W  assembled data word; held stable while word_valid=1.
- word_valid  out  1  word_out is valid.
- word_ready  in  1  consumer accepts the word on an edge where word_valid & word_ready.
- parity_err  out  1  sideband qualified by word_valid; 1 = received parity mismatched.
- frame_err  out  1  one-cycle pulse; stop bit was 1, frame discarded.
- overrun  out  1  sticky; a good frame completed while the holding register was occupied.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous:
  - state = IDLE, bit counter = 0, shift accumulator = 0.
  - word_out = 0, word_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0.
  - Reset mid-frame abandons the frame; no partial word is ever presented.
- en=0 edges: FSM, counter and accumulator hold. en gaps of any length inside a frame are legal.
- FSM, evaluated only on en=1 edges:
  - IDLE: bit_in=1 is the start bit -> DATA, counter = 0. bit_in=0 stays in IDLE.
  - DATA: shift bit_in in at the MSB end (accumulator shifts right), so the first data bit ends up in bit 0.
    - Counter increments each bit.
    - After the DATA_W-th bit: go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: compute mismatch = XOR(data bits) ^ bit_in (even parity), store it -> STOP.
  - STOP:
    - bit_in=0: frame good -> deliver. Go to IDLE.
    - bit_in=1: frame_err=1 for exactly the next cycle, word dropped, holding register and overrun untouched. Go to IDLE.
    - The stop bit is never reused as a start bit.
- Delivery, on the STOP edge with bit_in=0:
  - Holding register empty, or (word_valid & word_ready) on the same edge: load word_out and parity_err; word_valid=1 from the next cycle. Latency = 1 clk after the stop-bit edge.
  - Holding register full and word_ready=0: new word dropped, overrun set to 1 and held until rst.
- Handshake:
  - word_valid falls on the edge where word_valid & word_ready, unless a new word loads on that same edge (then word_valid stays 1 with new contents).
  - word_out and parity_err must not change while word_valid=1 and word_ready=0.
- Counter is width clog2(DATA_W+1) and must not wrap within a frame.
- A start bit may occur on the en edge immediately after the stop bit (back-to-back frames).

Decomposition:
- Shared package m0_pkg holds:
  - FSM state encoding: IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3.
  - Frame constants: START_LVL=1, STOP_LVL=0.
  - DATA_W default 16, shared with shift_reg users.
- One sub-module: m0_out_hold, the valid/ready holding register with overrun detection. FSM and accumulator stay in m0_serial_deframer.

Test Plan:
- Basic frame: after reset, send 1, then 0xA5C3 LSB-first, parity 0, stop 0, en=1 continuously, word_ready=1 -> word_valid for 1 cycle, word_out=0xA5C3, parity_err=0, one clk after the stop edge.
- Parity error: same frame with parity bit 1 -> word_out=0xA5C3, parity_err=1, frame_err=0.
- Framing error: frame 0x1234 with stop bit 1 -> frame_err pulses 1 cycle, word_valid stays 0. The next good frame 0x0001 is delivered correctly.
- Backpressure and overrun: word_ready=0, send 0x00FF then 0xFF00 -> word_out remains 0x00FF, overrun=1. Raise word_ready -> 0x00FF accepted, word_valid=0, overrun stays 1 until rst.
- Gaps and back-to-back:
  - en toggled 1/0 every cycle while sending 0xBEEF then immediately 0x0F0F -> both delivered in order.
  - word_ready held 1 -> simultaneous accept+load keeps word_valid high.
- Reset mid-frame: assert rst after 7 data bits of 0xFFFF -> all outputs 0, busy=0 immediately. Frame 0x8001 sent after release -> word_out=0x8001.
